management_register_bridge: RTL and testbench

- Parametrised successor to the management register read port: byte-wide management register space behind the QSPI interface or simulation bridge.
- Adds a write path, a bank of NUM_CFG_REGS writable config registers, parametrised address/length widths, a wait-state timeout, and a busy flag.
- Sits in the management clock domain between the QSPI/sim bridge and the device-info and config consumers.

---
 rtl/management_regs_pkg.sv | 50 +++++
 rtl/management_cfg_regfile.sv | 56 +++++
 rtl/management_register_bridge.sv | 153 +++++++++++++++
 tb/tb_management_register_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/management_regs_pkg.sv
// Shared address map and helpers for the management register space.
// The byte addresses below mirror the firmware FPGAInterface.h map.
package management_regs_pkg;

  // Device-info byte addresses, MSB first within each field.
  typedef enum logic [3:0] {
    RegIdcode0 = 4'd0,
    RegIdcode1 = 4'd1,
    RegIdcode2 = 4'd2,
    RegIdcode3 = 4'd3,
    RegSerial0 = 4'd4,
    RegSerial1 = 4'd5,
    RegSerial2 = 4'd6,
    RegSerial3 = 4'd7,
    RegSerial4 = 4'd8,
    RegSerial5 = 4'd9,
    RegSerial6 = 4'd10,
    RegSerial7 = 4'd11
  } regid_t;

  localparam int unsigned REG_FPGA_IDCODE  = 32'h0000;
  localparam int unsigned REG_FPGA_SERIAL  = 32'h0004;
  localparam int unsigned IDCODE_BYTES     = 4;
  localparam int unsigned SERIAL_BYTES     = 8;
  localparam int unsigned DEFAULT_CFG_BASE = 32'h0100;

  // Select one device-info byte; only meaningful for ids inside the enum range.
  function automatic logic [7:0] dev_info_byte(input regid_t id, input logic [31:0] idcode,
                                               input logic [63:0] serial);
    logic [7:0] b;
    b = 8'h00;
    case (id)
      RegIdcode0: b = idcode[31:24];
      RegIdcode1: b = idcode[23:16];
      RegIdcode2: b = idcode[15:8];
      RegIdcode3: b = idcode[7:0];
      RegSerial0: b = serial[63:56];
      RegSerial1: b = serial[55:48];
      RegSerial2: b = serial[47:40];
      RegSerial3: b = serial[39:32];
      RegSerial4: b = serial[31:24];
      RegSerial5: b = serial[23:16];
      RegSerial6: b = serial[15:8];
      RegSerial7: b = serial[7:0];
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/management_cfg_regfile.sv
// Bank of byte-wide writable config registers with per-register write strobes
// and a combinational read port.
module management_cfg_regfile
  import management_regs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned NUM_CFG_REGS = 8,
  parameter int unsigned CFG_BASE     = DEFAULT_CFG_BASE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [7:0]                wr_data,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_hit,
  output logic [7:0]                rd_data,
  output logic [8*NUM_CFG_REGS-1:0] cfg_regs,
  output logic [NUM_CFG_REGS-1:0]   cfg_wr_strobe
);

  localparam int unsigned IdxW = (NUM_CFG_REGS > 1) ? $clog2(NUM_CFG_REGS) : 1;

  logic [NUM_CFG_REGS-1:0][7:0] regs_q;
  logic [NUM_CFG_REGS-1:0]      strobe_q;
  logic                         wr_hit;
  logic [IdxW-1:0]              wr_idx;
  logic [IdxW-1:0]              rd_idx;

  // Address decode; unsigned wrap of (addr - base) folds both range bounds into one compare.
  always_comb begin
    wr_hit  = wr_en && ((32'(wr_addr) - CFG_BASE) < NUM_CFG_REGS);
    wr_idx  = IdxW'(32'(wr_addr) - CFG_BASE);
    rd_hit  = (32'(rd_addr) - CFG_BASE) < NUM_CFG_REGS;
    rd_idx  = IdxW'(32'(rd_addr) - CFG_BASE);
    rd_data = rd_hit ? regs_q[rd_idx] : 8'h00;
  end

  // Register update and one-cycle strobe for the written register.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      strobe_q <= '0;
    end else begin
      strobe_q <= '0;
      if (wr_hit) begin
        regs_q[wr_idx]   <= wr_data;
        strobe_q[wr_idx] <= 1'b1;
      end
    end
  end

  assign cfg_regs      = regs_q;
  assign cfg_wr_strobe = strobe_q;

endmodule

// File: rtl/management_register_bridge.sv
// Byte-wide management register space: burst read FSM with wait-state timeout,
// device-info decode and a writable config register bank.
module management_register_bridge
  import management_regs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned NUM_CFG_REGS = 8,
  parameter int unsigned CFG_BASE     = DEFAULT_CFG_BASE,
  parameter int unsigned WAIT_TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [LEN_WIDTH-1:0]      rd_len,
  output logic                      rd_valid,
  output logic [7:0]                rd_data,
  output logic                      rd_timeout,
  output logic                      rd_busy,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [7:0]                wr_data,
  input  logic                      idcode_valid,
  input  logic [31:0]               idcode,
  input  logic                      die_serial_valid,
  input  logic [63:0]               die_serial,
  output logic [8*NUM_CFG_REGS-1:0] cfg_regs,
  output logic [NUM_CFG_REGS-1:0]   cfg_wr_strobe
);

  localparam int unsigned WaitW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [LEN_WIDTH-1:0] LenOne  = LEN_WIDTH'(1);
  localparam logic [WaitW-1:0]     WaitOne = WaitW'(1);

  typedef enum logic [0:0] {StIdle, StRead} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic [WaitW-1:0]      wait_q;
  logic                  rd_valid_q;
  logic [7:0]            rd_data_q;
  logic                  rd_timeout_q;
  logic                  rd_busy_q;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  is_idcode;
  logic                  is_serial;
  logic                  src_ready;
  logic                  timed_out;
  logic                  last_byte;
  logic                  cfg_hit;
  logic [7:0]            cfg_rd_data;
  logic [7:0]            dec_data;

  management_cfg_regfile #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .NUM_CFG_REGS (NUM_CFG_REGS),
    .CFG_BASE     (CFG_BASE)
  ) u_cfg_regfile (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (cur_addr),
    .rd_hit        (cfg_hit),
    .rd_data       (cfg_rd_data),
    .cfg_regs      (cfg_regs),
    .cfg_wr_strobe (cfg_wr_strobe)
  );

  // Current burst address, source readiness and read mux.
  always_comb begin
    cur_addr  = base_q + ADDR_WIDTH'(count_q);
    is_idcode = (32'(cur_addr) - REG_FPGA_IDCODE) < IDCODE_BYTES;
    is_serial = (32'(cur_addr) - REG_FPGA_SERIAL) < SERIAL_BYTES;
    src_ready = !((is_idcode && !idcode_valid) || (is_serial && !die_serial_valid));
    timed_out = (WAIT_TIMEOUT != 0) && (32'(wait_q) == WAIT_TIMEOUT);
    last_byte = (count_q + LenOne) == len_q;
    if (is_idcode || is_serial) begin
      dec_data = dev_info_byte(regid_t'(cur_addr[3:0]), idcode, die_serial);
    end else if (cfg_hit) begin
      dec_data = cfg_rd_data;
    end else begin
      dec_data = 8'h00;
    end
  end

  // Burst FSM with registered outputs; a new rd_en always wins over the byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      len_q        <= '0;
      count_q      <= '0;
      wait_q       <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 8'h00;
      rd_timeout_q <= 1'b0;
      rd_busy_q    <= 1'b0;
    end else begin
      rd_valid_q   <= 1'b0;
      rd_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rd_en && (rd_len != '0)) begin
            base_q    <= rd_addr;
            len_q     <= rd_len;
            count_q   <= '0;
            wait_q    <= '0;
            state_q   <= StRead;
            rd_busy_q <= 1'b1;
          end
        end
        StRead: begin
          if (rd_en) begin
            if (rd_len != '0) begin
              base_q  <= rd_addr;
              len_q   <= rd_len;
              count_q <= '0;
              wait_q  <= '0;
            end else begin
              state_q   <= StIdle;
              rd_busy_q <= 1'b0;
            end
          end else if (src_ready || timed_out) begin
            rd_valid_q   <= 1'b1;
            rd_data_q    <= src_ready ? dec_data : 8'h00;
            rd_timeout_q <= !src_ready;
            wait_q       <= '0;
            count_q      <= count_q + LenOne;
            if (last_byte) begin
              state_q   <= StIdle;
              rd_busy_q <= 1'b0;
            end
          end else begin
            wait_q <= wait_q + WaitOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_timeout = rd_timeout_q;
  assign rd_busy    = rd_busy_q;

endmodule

// File: tb/tb_management_register_bridge.sv
// Scoreboard bench for management_register_bridge: expected bytes (data, timeout
// flag, arrival cycle) are queued at stimulus time and popped on rd_valid.
module tb_management_register_bridge;
  import management_regs_pkg::*;

  localparam int unsigned CBASE = 32'h0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_en, rd_en_to;
  logic [15:0] rd_addr, rd_len;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        idcode_valid, die_serial_valid;
  logic [31:0] idcode;
  logic [63:0] die_serial;

  logic        rd_valid, rd_timeout, rd_busy;
  logic [7:0]  rd_data;
  logic [63:0] cfg_regs;
  logic [7:0]  cfg_wr_strobe;

  logic        rd_valid_t, rd_timeout_t, rd_busy_t;
  logic [7:0]  rd_data_t;
  logic [63:0] cfg_regs_t;
  logic [7:0]  cfg_wr_strobe_t;

  management_register_bridge dut (
    .clk (clk), .rst (rst),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_len (rd_len),
    .rd_valid (rd_valid), .rd_data (rd_data), .rd_timeout (rd_timeout), .rd_busy (rd_busy),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .idcode_valid (idcode_valid), .idcode (idcode),
    .die_serial_valid (die_serial_valid), .die_serial (die_serial),
    .cfg_regs (cfg_regs), .cfg_wr_strobe (cfg_wr_strobe)
  );

  management_register_bridge #(.WAIT_TIMEOUT (15)) dut_to (
    .clk (clk), .rst (rst),
    .rd_en (rd_en_to), .rd_addr (rd_addr), .rd_len (rd_len),
    .rd_valid (rd_valid_t), .rd_data (rd_data_t), .rd_timeout (rd_timeout_t),
    .rd_busy (rd_busy_t),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .idcode_valid (idcode_valid), .idcode (idcode),
    .die_serial_valid (die_serial_valid), .die_serial (die_serial),
    .cfg_regs (cfg_regs_t), .cfg_wr_strobe (cfg_wr_strobe_t)
  );

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t q_to[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_read(input logic [15:0] a, input logic [15:0] l);
    rd_addr = a;
    rd_len  = l;
    rd_en   = 1'b1;
    tick(1);
    rd_en   = 1'b0;
  endtask

  task automatic start_read_to(input logic [15:0] a, input logic [15:0] l);
    rd_addr  = a;
    rd_len   = l;
    rd_en_to = 1'b1;
    tick(1);
    rd_en_to = 1'b0;
  endtask

  task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
  endtask

  // Default-instance monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rd_valid) begin
      if (q.size() == 0) begin
        check_eq("unexpected_valid", rd_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check_eq("rd_data", rd_data, e.data);
        check_eq("rd_timeout", rd_timeout, e.to);
        if (e.cyc >= 0) check_eq("rd_cycle", cyc, e.cyc);
      end
    end
  end

  // Timeout-instance monitor.
  always @(negedge clk) begin : mon_to
    exp_t e;
    if (rd_valid_t) begin
      if (q_to.size() == 0) begin
        check_eq("unexpected_valid_to", rd_valid_t, 1'b0);
      end else begin
        e = q_to.pop_front();
        check_eq("to_rd_data", rd_data_t, e.data);
        check_eq("to_rd_timeout", rd_timeout_t, e.to);
        check_eq("to_rd_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    logic [63:0] exp_cfg;

    rst = 1'b1;
    rd_en = 1'b0; rd_en_to = 1'b0; rd_addr = '0; rd_len = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    idcode_valid = 1'b0; die_serial_valid = 1'b0;
    idcode = 32'h0362D093;
    die_serial = 64'h0123_4567_89AB_CDEF;
    exp_cfg = '0;
    tick(3);
    check_eq("rst_valid", rd_valid, 1'b0);
    check_eq("rst_data", rd_data, 8'h00);
    check_eq("rst_timeout", rd_timeout, 1'b0);
    check_eq("rst_busy", rd_busy, 1'b0);
    check_eq("rst_cfg", cfg_regs, 64'h0);
    check_eq("rst_strobe", cfg_wr_strobe, 8'h00);
    rst = 1'b0;
    idcode_valid = 1'b1;
    die_serial_valid = 1'b1;
    tick(2);

    // IDCODE burst, first byte two cycles after rd_en.
    c0 = cyc;
    for (int k = 0; k < 4; k++) q.push_back('{8'(idcode >> (24 - 8 * k)), 1'b0, c0 + 2 + k});
    start_read(16'h0000, 16'd4);
    tick(1);
    check_eq("busy_mid", rd_busy, 1'b1);
    tick(5);
    check_eq("busy_done", rd_busy, 1'b0);

    // Serial burst stalled until the source becomes valid.
    die_serial_valid = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 8; k++) q.push_back('{8'(die_serial >> (56 - 8 * k)), 1'b0, c0 + 21 + k});
    start_read(16'h0004, 16'd8);
    tick(19);
    die_serial_valid = 1'b1;
    tick(12);

    // Wait-state timeout on the WAIT_TIMEOUT=15 instance.
    idcode_valid = 1'b0;
    c0 = cyc;
    q_to.push_back('{8'h00, 1'b1, c0 + 17});
    q_to.push_back('{8'h00, 1'b1, c0 + 33});
    start_read_to(16'h0000, 16'd2);
    tick(40);
    idcode_valid = 1'b1;
    tick(1);

    // Config write and strobe; a read-only write is dropped.
    write_byte(16'(CBASE + 3), 8'hA5);
    exp_cfg[31:24] = 8'hA5;
    check_eq("cfg_after_wr", cfg_regs, exp_cfg);
    check_eq("strobe_pulse", cfg_wr_strobe, 8'h08);
    tick(1);
    check_eq("strobe_clear", cfg_wr_strobe, 8'h00);
    write_byte(16'h0000, 8'h77);
    check_eq("cfg_ro_write", cfg_regs, exp_cfg);
    check_eq("strobe_ro_write", cfg_wr_strobe, 8'h00);
    tick(1);

    // Read/write collision returns the old value; next read sees the new one.
    c0 = cyc;
    q.push_back('{8'hA5, 1'b0, c0 + 2});
    q.push_back('{8'h00, 1'b0, c0 + 3});
    start_read(16'(CBASE + 3), 16'd2);
    write_byte(16'(CBASE + 3), 8'h5A);
    exp_cfg[31:24] = 8'h5A;
    tick(3);
    c0 = cyc;
    q.push_back('{8'h5A, 1'b0, c0 + 2});
    start_read(16'(CBASE + 3), 16'd1);
    tick(3);
    check_eq("cfg_collide", cfg_regs, exp_cfg);

    // Address wrap from 0xFFFE into the IDCODE bytes.
    c0 = cyc;
    q.push_back('{8'h00, 1'b0, c0 + 2});
    q.push_back('{8'h00, 1'b0, c0 + 3});
    q.push_back('{idcode[31:24], 1'b0, c0 + 4});
    q.push_back('{idcode[23:16], 1'b0, c0 + 5});
    start_read(16'hFFFE, 16'd4);
    tick(6);

    // Restart three bytes into a serial burst.
    c0 = cyc;
    for (int k = 0; k < 3; k++) q.push_back('{8'(die_serial >> (56 - 8 * k)), 1'b0, c0 + 2 + k});
    q.push_back('{idcode[31:24], 1'b0, c0 + 6});
    start_read(16'h0004, 16'd8);
    tick(3);
    start_read(16'h0000, 16'd1);
    tick(8);

    // Reset mid-burst: two bytes out, then nothing, config cleared.
    c0 = cyc;
    q.push_back('{idcode[31:24], 1'b0, c0 + 2});
    q.push_back('{idcode[23:16], 1'b0, c0 + 3});
    start_read(16'h0000, 16'd4);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("rst_mid_cfg", cfg_regs, 64'h0);
    check_eq("rst_mid_busy", rd_busy, 1'b0);
    tick(6);

    // Zero-length read is a no-op.
    start_read(16'h0000, 16'd0);
    check_eq("len0_busy", rd_busy, 1'b0);
    tick(6);

    check_eq("q_left", q.size(), 0);
    check_eq("q_to_left", q_to.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
